core_sequencer: RTL and testbench

Multi-cycle control FSM for the simple RISC-V core. It drives instruction fetch and data-memory handshakes and resolves branch conditions from the ALU ZCNV flags. It produces the per-instruction strobes: PC advance, branch-taken select and register-file write. It sits between the instruction/data memory ports, the decoder (which supplies instruction type and fun3) and the PC-update/register-file datapath.

---
 rtl/core_sequencer_if.sv | 28 ++
 rtl/core_sequencer.sv | 161 ++++++++++++++++
 tb/tb_core_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle for the core sequencer.
// The sequencer is the master; memories (or a bench) take the slave side.
interface core_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the simple RISC-V core: fetch, decode, execute,
// optional data access, write-back. Resolves branches from the ALU ZCNV flags
// and traps into a sticky HALT on an illegal type, illegal branch funct3, or a
// memory handshake that outlives TIMEOUT request cycles.
module core_sequencer #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  core_sequencer_if.master     mem,
  output logic [31:0]          ir,
  input  logic [3:0]           inst_type,
  input  logic [2:0]           fun3,
  input  logic [3:0]           zcnv,
  output logic                 pc_en,
  output logic                 take_imm,
  output logic                 rf_we,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  // Last count value before the limit: a miss on this cycle is the TIMEOUT-th.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        imem_req_q;
  logic [7:0]  tmo_cnt;
  logic [3:0]  type_q;
  logic [2:0]  fun3_q;
  logic        take_imm_r;
  logic        take_dec;
  logic        trap_set;

  logic flag_z, flag_c, flag_n, flag_v;
  assign {flag_z, flag_c, flag_n, flag_v} = zcnv;

  // A fetch completes only while the request is actually presented.
  logic fetch_done, mem_done, req_active, ack_now, tmo_hit;
  assign fetch_done = (state_q == S_FETCH) && imem_req_q && mem.imem_ack;
  assign mem_done   = (state_q == S_MEM) && mem.dmem_ack;
  assign req_active = ((state_q == S_FETCH) && imem_req_q) || (state_q == S_MEM);
  assign ack_now    = fetch_done || mem_done;
  // An ack on the limit cycle wins over the timeout.
  assign tmo_hit    = req_active && !ack_now && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and branch resolution.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_d  = state_q;
    take_dec = 1'b0;

    unique case (type_q)
      4'd5, 4'd7, 4'd8: take_dec = 1'b1;
      4'd6: begin
        unique case (fun3_q)
          3'b000:  take_dec = flag_z;
          3'b001:  take_dec = !flag_z;
          3'b100:  take_dec = flag_n ^ flag_v;
          3'b101:  take_dec = !(flag_n ^ flag_v);
          3'b110:  take_dec = flag_c;
          3'b111:  take_dec = !flag_c;
          default: take_dec = 1'b0;
        endcase
      end
      default: take_dec = 1'b0;
    endcase

    unique case (state_q)
      S_FETCH: begin
        if (fetch_done)   state_d = S_DECODE;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = (inst_type > 4'd8) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (type_q == 4'd6 && fun3_q[2:1] == 2'b01)   state_d = S_HALT;
        else if (type_q == 4'd0 || type_q == 4'd2)    state_d = S_MEM;
        else                                          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_done)     state_d = S_WB;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Every way into HALT is a fault.
  assign trap_set = (state_d == S_HALT) && (state_q != S_HALT);

  // Datapath registers: fetch request, timeout counter, IR, decoded fields,
  // branch decision, retire counter and sticky trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req_q <= 1'b0;
      tmo_cnt    <= 8'd0;
      ir         <= 32'd0;
      type_q     <= 4'd0;
      fun3_q     <= 3'd0;
      take_imm_r <= 1'b0;
      instret    <= '0;
      trap       <= 1'b0;
    end else begin
      // Registered so the request is low on the cycle right after reset.
      imem_req_q <= (state_d == S_FETCH);

      if (state_d != state_q)        tmo_cnt <= 8'd0;
      else if (req_active && !ack_now) tmo_cnt <= tmo_cnt + 8'd1;

      if (fetch_done) ir <= mem.imem_rdata;

      if (state_q == S_DECODE) begin
        type_q <= inst_type;
        fun3_q <= fun3;
      end

      if (state_q == S_EXEC) take_imm_r <= take_dec;
      if (state_q == S_WB)   instret    <= instret + INSTRET_W'(1);
      if (trap_set)          trap       <= 1'b1;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    pc_en        = (state_q == S_WB);
    take_imm     = (state_q == S_WB) && take_imm_r;
    rf_we        = 1'b0;
    if (state_q == S_WB) begin
      unique case (type_q)
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8: rf_we = 1'b1;
        default:                                  rf_we = 1'b0;
      endcase
    end
    mem.imem_req = imem_req_q;
    mem.dmem_req = (state_q == S_MEM);
    mem.dmem_we  = (state_q == S_MEM) && (type_q == 4'd2);
    state        = state_q;
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. Each instruction is expanded into
// its expected cycle-by-cycle trace from the sequencing rules; a single
// compare process checks every cycle of that trace against the DUT.
module tb_core_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [31:0] ir;
  logic [3:0] inst_type = 4'd0;
  logic [2:0] fun3 = 3'd0;
  logic [3:0] zcnv = 4'd0;
  logic       pc_en, take_imm, rf_we, trap;
  logic [2:0] state;
  logic [2:0] instret;

  core_sequencer_if bus ();

  core_sequencer #(.TIMEOUT(TMO), .INSTRET_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus.master),
    .ir        (ir),
    .inst_type (inst_type),
    .fun3      (fun3),
    .zcnv      (zcnv),
    .pc_en     (pc_en),
    .take_imm  (take_imm),
    .rf_we     (rf_we),
    .state     (state),
    .instret   (instret),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    // stimulus for the cycle
    logic        ia, da;
    logic [31:0] rd;
    logic [3:0]  ty;
    logic [2:0]  f3;
    logic [3:0]  zf;
    // expected outputs for the cycle
    logic [2:0]  st;
    logic        ireq, dreq, dwe, pc, ti, rw, tr;
    logic [31:0] ir;
    logic [2:0]  ret;
  } rec_t;

  rec_t plan[$];
  rec_t exp_q[$];
  rec_t cmp_e;

  int n_vec = 0;
  int n_bad = 0;
  int pc_cnt = 0;
  int dreq_cnt = 0;

  // model state
  logic [31:0] m_ir;
  logic [2:0]  m_ret;
  logic        m_trap;
  logic [31:0] cw;
  logic [3:0]  cty;
  logic [2:0]  cf3;
  logic [3:0]  czf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ia, input logic da, input logic [2:0] st,
                     input logic ireq, input logic dreq, input logic dwe,
                     input logic pc, input logic ti, input logic rw);
    rec_t r;
    r.ia = ia; r.da = da; r.rd = cw; r.ty = cty; r.f3 = cf3; r.zf = czf;
    r.st = st; r.ireq = ireq; r.dreq = dreq; r.dwe = dwe;
    r.pc = pc; r.ti = ti; r.rw = rw; r.tr = m_trap;
    r.ir = m_ir; r.ret = m_ret;
    plan.push_back(r);
  endtask

  task automatic halt_tail();
    m_trap = 1'b1;
    repeat (3) add(1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected trace of one instruction: fw fetch wait cycles, mw data wait cycles.
  task automatic build(input logic [31:0] w, input logic [3:0] ty, input logic [2:0] f3,
                       input logic [3:0] zf, input int fw, input int mw);
    logic z, c, n, v, ti, rw, st_op;
    cw = w; cty = ty; cf3 = f3; czf = zf;
    {z, c, n, v} = zf;
    if (fw + 1 > TMO) begin
      repeat (TMO) add(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      halt_tail();
      return;
    end
    repeat (fw) add(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_ir = w;
    add(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ty > 4'd8) begin halt_tail(); return; end
    add(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ty == 4'd6 && (f3 == 3'd2 || f3 == 3'd3)) begin halt_tail(); return; end
    case (ty)
      4'd5, 4'd7, 4'd8: ti = 1'b1;
      4'd6: case (f3)
        3'd0: ti = z;
        3'd1: ti = !z;
        3'd4: ti = n != v;
        3'd5: ti = n == v;
        3'd6: ti = c;
        default: ti = !c;
      endcase
      default: ti = 1'b0;
    endcase
    rw = !(ty == 4'd2 || ty == 4'd6);
    if (ty == 4'd0 || ty == 4'd2) begin
      st_op = (ty == 4'd2);
      if (mw + 1 > TMO) begin
        repeat (TMO) add(1'b0, 1'b0, 3'd3, 1'b0, 1'b1, st_op, 1'b0, 1'b0, 1'b0);
        halt_tail();
        return;
      end
      repeat (mw) add(1'b0, 1'b0, 3'd3, 1'b0, 1'b1, st_op, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, st_op, 1'b0, 1'b0, 1'b0);
    end
    add(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, ti, rw);
    m_ret = m_ret + 3'd1;
  endtask

  // Drive up to n planned cycles (n < 0: all), handing each to the checker.
  task automatic apply_plan(input int n);
    rec_t r;
    int k = 0;
    while (plan.size() > 0) begin
      if (n >= 0 && k >= n) begin
        plan.delete();
        break;
      end
      r = plan.pop_front();
      bus.imem_ack = r.ia; bus.dmem_ack = r.da; bus.imem_rdata = r.rd;
      inst_type = r.ty; fun3 = r.f3; zcnv = r.zf;
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      k++;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ir = 32'd0; m_ret = 3'd0; m_trap = 1'b0;
    cw = 32'd0; cty = 4'd0; cf3 = 3'd0; czf = 4'd0;
    add(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_plan(-1);
    pc_cnt = 0;
  endtask

  // Per-cycle comparison against the expected trace.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      check("ctl", {54'd0, state, bus.imem_req, bus.dmem_req, bus.dmem_we, pc_en, take_imm, rf_we, trap},
            {54'd0, cmp_e.st, cmp_e.ireq, cmp_e.dreq, cmp_e.dwe, cmp_e.pc, cmp_e.ti, cmp_e.rw, cmp_e.tr});
      check("ir", {32'd0, ir}, {32'd0, cmp_e.ir});
      check("instret", {61'd0, instret}, {61'd0, cmp_e.ret});
    end
  end

  // Strobe counters for the hand-computed checks.
  always @(negedge clk) begin
    if (pc_en)        pc_cnt++;
    if (bus.dmem_req) dreq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Register-type instruction, ack in first fetch cycle.
    do_reset();
    build(32'h0020_8133, 4'd3, 3'd0, 4'd0, 0, 0);
    apply_plan(-1);
    check("first_instret", {61'd0, instret}, 64'd1);
    check("first_pc_pulses", 64'(pc_cnt), 64'd1);

    // Branches across funct3/flag combinations.
    build(32'h0000_1063, 4'd6, 3'd1, 4'b0000, 1, 0); apply_plan(-1);
    build(32'h0000_1063, 4'd6, 3'd1, 4'b1000, 0, 0); apply_plan(-1);
    build(32'h0000_0063, 4'd6, 3'd0, 4'b1000, 0, 0); apply_plan(-1);
    build(32'h0000_4063, 4'd6, 3'd4, 4'b0010, 2, 0); apply_plan(-1);
    build(32'h0000_5063, 4'd6, 3'd5, 4'b0010, 0, 0); apply_plan(-1);
    build(32'h0000_6063, 4'd6, 3'd6, 4'b0100, 0, 0); apply_plan(-1);
    build(32'h0000_7063, 4'd6, 3'd7, 4'b0100, 0, 0); apply_plan(-1);
    // Jumps and upper-immediate types; fetch ack exactly on the limit cycle.
    build(32'h0040_006F, 4'd8, 3'd0, 4'd0, 3, 0); apply_plan(-1);
    build(32'h1234_5037, 4'd4, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    build(32'h0000_1017, 4'd5, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    build(32'h0000_8067, 4'd7, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    // Load with data ack on the limit cycle, then a store.
    dreq_cnt = 0;
    build(32'h0000_2083, 4'd0, 3'd2, 4'd0, 0, 3); apply_plan(-1);
    check("load_dreq_cycles", 64'(dreq_cnt), 64'd4);
    build(32'h0010_2023, 4'd2, 3'd2, 4'd0, 0, 1); apply_plan(-1);

    // Illegal type in DECODE.
    do_reset();
    build(32'h0010_0093, 4'd1, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    pc_cnt = 0;
    build(32'hFFFF_FFFF, 4'd9, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    check("illegal_instret", {61'd0, instret}, 64'd1);
    check("illegal_trap", {63'd0, trap}, 64'd1);
    check("illegal_no_pc", 64'(pc_cnt), 64'd0);

    // Fetch never acknowledged.
    do_reset();
    build(32'h0000_0013, 4'd1, 3'd0, 4'd0, 10, 0); apply_plan(-1);
    check("tmo_state", {61'd0, state}, 64'd7);
    check("tmo_trap", {63'd0, trap}, 64'd1);
    check("tmo_imem_req", {63'd0, bus.imem_req}, 64'd0);

    // Illegal branch funct3.
    do_reset();
    build(32'h0000_2063, 4'd6, 3'd2, 4'd0, 0, 0); apply_plan(-1);

    // Reset in the middle of a data access.
    do_reset();
    build(32'h0020_8133, 4'd3, 3'd0, 4'd0, 0, 0); apply_plan(-1);
    build(32'h0000_2083, 4'd0, 3'd2, 4'd0, 0, 5); apply_plan(5);
    check("mid_mem_dreq", {63'd0, bus.dmem_req}, 64'd1);
    do_reset();

    // Data access never acknowledged.
    build(32'h0010_2023, 4'd2, 3'd2, 4'd0, 0, 10); apply_plan(-1);

    // Retire counter wraps (3 bits here).
    do_reset();
    repeat (10) begin
      build(32'h0010_0093, 4'd1, 3'd0, 4'd0, 0, 0);
      apply_plan(-1);
    end
    check("instret_wrap", {61'd0, instret}, 64'd2);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
